// File: rtl/audio_memory_scheduler.sv
// Record/playback session sequencer and single-port DDR command arbiter
// with a one-entry write holding buffer and trace-length bookkeeping.
module audio_memory_scheduler #(
   parameter int ADDR_WIDTH   = 27,
   parameter int DATA_WIDTH   = 64,
   parameter int PACKET_BYTES = DATA_WIDTH / 8
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  start_record_i,
   input  logic                  start_playback_i,
   input  logic                  stop_i,
   output logic                  recording_o,
   output logic                  playing_o,
   output logic                  trace_end_o,
   output logic                  memory_full_o,
   output logic                  overflow_o,
   input  logic                  wr_valid_i,
   input  logic [DATA_WIDTH-1:0] wr_data_i,
   input  logic                  rd_req_i,
   output logic                  rd_valid_o,
   output logic [DATA_WIDTH-1:0] rd_data_o,
   input  logic                  ddr_ready_i,
   output logic                  ddr_write_o,
   output logic                  ddr_read_o,
   output logic [ADDR_WIDTH-1:0] ddr_address_o,
   output logic [DATA_WIDTH-1:0] ddr_write_data_o,
   input  logic                  ddr_write_done_i,
   input  logic                  ddr_read_valid_i,
   input  logic [DATA_WIDTH-1:0] ddr_read_data_i
);

   typedef enum logic [2:0] {
      S_IDLE, S_RECORD, S_DRAIN, S_PLAY, S_STOP
   } sess_e;

   typedef enum logic [1:0] {
      M_IDLE, M_WRITE, M_READ
   } mem_e;

   // Pointers carry one extra bit so "top of memory" is representable.
   localparam int PW = ADDR_WIDTH + 1;
   localparam logic [PW-1:0] PB = PW'(PACKET_BYTES);

   sess_e sess_q, sess_d;
   mem_e  mem_q, mem_d;

   logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
   logic [PW-1:0]         trace_len_q, trace_len_d;
   logic [DATA_WIDTH-1:0] buf_q, buf_d;
   logic                  buf_full_q, buf_full_d;
   logic                  rd_pend_q, rd_pend_d;
   logic                  mem_full_q, mem_full_d;
   logic                  ovf_q, ovf_d;
   logic                  tend_q, tend_d;
   logic                  rd_valid_q, rd_valid_d;
   logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
   logic                  ddr_wr_q, ddr_wr_d;
   logic                  ddr_rd_q, ddr_rd_d;
   logic [ADDR_WIDTH-1:0] ddr_addr_q, ddr_addr_d;
   logic [DATA_WIDTH-1:0] ddr_wdata_q, ddr_wdata_d;

   logic          issue_wr;
   logic          issue_rd;
   logic          drain_done;
   logic          play_done;
   logic          wr_ok;
   logic          capture;
   logic          drop;
   logic          idle_rec;
   logic          idle_play;
   logic [PW-1:0] wr_ptr_nx;

   assign wr_ptr_nx = wr_ptr_q + PB;
   assign idle_rec  = (sess_q == S_IDLE) && start_record_i;
   assign idle_play = (sess_q == S_IDLE) && !start_record_i
                      && start_playback_i;

   assign issue_wr = (mem_q == M_IDLE) && ddr_ready_i && buf_full_q
                     && !wr_ptr_q[ADDR_WIDTH];
   assign issue_rd = (mem_q == M_IDLE) && ddr_ready_i && !issue_wr
                     && rd_pend_q && (rd_ptr_q < trace_len_q)
                     && (sess_q == S_PLAY);

   // A full memory strands any buffered packet, so drain must not wait on it.
   assign drain_done = (sess_q == S_DRAIN) && (mem_q == M_IDLE)
                       && (!buf_full_q || mem_full_q);
   assign play_done  = (sess_q == S_PLAY) && (rd_ptr_q == trace_len_q)
                       && (mem_q == M_IDLE) && !rd_pend_q;

   assign wr_ok   = wr_valid_i && (sess_q == S_RECORD);
   assign capture = wr_ok && (!buf_full_q || issue_wr);
   assign drop    = wr_ok && buf_full_q && !issue_wr;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sess_q      <= S_IDLE;
         mem_q       <= M_IDLE;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         trace_len_q <= '0;
         buf_q       <= '0;
         buf_full_q  <= 1'b0;
         rd_pend_q   <= 1'b0;
         mem_full_q  <= 1'b0;
         ovf_q       <= 1'b0;
         tend_q      <= 1'b0;
         rd_valid_q  <= 1'b0;
         rd_data_q   <= '0;
         ddr_wr_q    <= 1'b0;
         ddr_rd_q    <= 1'b0;
         ddr_addr_q  <= '0;
         ddr_wdata_q <= '0;
      end else begin
         sess_q      <= sess_d;
         mem_q       <= mem_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         trace_len_q <= trace_len_d;
         buf_q       <= buf_d;
         buf_full_q  <= buf_full_d;
         rd_pend_q   <= rd_pend_d;
         mem_full_q  <= mem_full_d;
         ovf_q       <= ovf_d;
         tend_q      <= tend_d;
         rd_valid_q  <= rd_valid_d;
         rd_data_q   <= rd_data_d;
         ddr_wr_q    <= ddr_wr_d;
         ddr_rd_q    <= ddr_rd_d;
         ddr_addr_q  <= ddr_addr_d;
         ddr_wdata_q <= ddr_wdata_d;
      end
   end

   always_comb begin
      sess_d = sess_q;
      unique case (sess_q)
         S_IDLE: begin
            if (start_record_i)        sess_d = S_RECORD;
            else if (start_playback_i) sess_d = S_PLAY;
         end
         S_RECORD: if (stop_i || mem_full_q) sess_d = S_DRAIN;
         S_DRAIN:  if (drain_done) sess_d = S_IDLE;
         S_PLAY: begin
            if (play_done)   sess_d = S_IDLE;
            else if (stop_i) sess_d = S_STOP;
         end
         S_STOP:   if (mem_q == M_IDLE) sess_d = S_IDLE;
         default:  sess_d = S_IDLE;
      endcase
   end

   always_comb begin
      mem_d = mem_q;
      unique case (mem_q)
         M_IDLE: begin
            if (issue_wr)      mem_d = M_WRITE;
            else if (issue_rd) mem_d = M_READ;
         end
         M_WRITE: if (ddr_write_done_i) mem_d = M_IDLE;
         M_READ:  if (ddr_read_valid_i) mem_d = M_IDLE;
         default: mem_d = M_IDLE;
      endcase
   end

   always_comb begin
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      trace_len_d = trace_len_q;
      buf_d       = buf_q;
      buf_full_d  = buf_full_q;
      rd_pend_d   = rd_pend_q;
      mem_full_d  = mem_full_q;
      ovf_d       = ovf_q;

      if (idle_rec) begin
         wr_ptr_d   = '0;
         mem_full_d = 1'b0;
         ovf_d      = 1'b0;
      end
      if (idle_play) rd_ptr_d = '0;

      if (issue_wr) begin
         wr_ptr_d = wr_ptr_nx;
         if (wr_ptr_nx[ADDR_WIDTH]) mem_full_d = 1'b1;
      end
      if (issue_rd) rd_ptr_d = rd_ptr_q + PB;
      if (drain_done) trace_len_d = wr_ptr_q;

      if (capture) begin
         buf_d      = wr_data_i;
         buf_full_d = 1'b1;
      end else if (issue_wr || drain_done) begin
         buf_full_d = 1'b0;
      end
      if (drop) ovf_d = 1'b1;

      if (sess_q != S_PLAY) begin
         rd_pend_d = 1'b0;
      end else if (issue_rd) begin
         rd_pend_d = 1'b0;
      end else if (rd_req_i && !rd_pend_q && (mem_q != M_READ)
                   && (rd_ptr_q != trace_len_q)) begin
         rd_pend_d = 1'b1;
      end
   end

   always_comb begin
      tend_d      = play_done;
      rd_valid_d  = (mem_q == M_READ) && ddr_read_valid_i
                    && (sess_q == S_PLAY);
      rd_data_d   = rd_valid_d ? ddr_read_data_i : rd_data_q;
      ddr_wr_d    = issue_wr;
      ddr_rd_d    = issue_rd;
      ddr_addr_d  = '0;
      ddr_wdata_d = '0;
      if (issue_wr) begin
         ddr_addr_d  = wr_ptr_q[ADDR_WIDTH-1:0];
         ddr_wdata_d = buf_q;
      end else if (issue_rd) begin
         ddr_addr_d  = rd_ptr_q[ADDR_WIDTH-1:0];
      end
   end

   always_comb begin
      recording_o      = (sess_q == S_RECORD) || (sess_q == S_DRAIN);
      playing_o        = (sess_q == S_PLAY);
      trace_end_o      = tend_q;
      memory_full_o    = mem_full_q;
      overflow_o       = ovf_q;
      rd_valid_o       = rd_valid_q;
      rd_data_o        = rd_data_q;
      ddr_write_o      = ddr_wr_q;
      ddr_read_o       = ddr_rd_q;
      ddr_address_o    = ddr_addr_q;
      ddr_write_data_o = ddr_wdata_q;
   end

endmodule

// File: tb/tb_audio_memory_scheduler.sv
// Directed bench for audio_memory_scheduler: a full-size instance and a
// 6-bit-address instance share inputs; a small DDR model answers commands.
module tb_audio_memory_scheduler;

   logic        clk = 1'b0;
   logic        rst_i = 1'b1;
   logic        start_record_i = 1'b0;
   logic        start_playback_i = 1'b0;
   logic        stop_i = 1'b0;
   logic        wr_valid_i = 1'b0;
   logic [63:0] wr_data_i = '0;
   logic        rd_req_i = 1'b0;
   logic        ddr_ready_i = 1'b1;
   logic        ddr_write_done_i = 1'b0;
   logic        ddr_read_valid_i = 1'b0;
   logic [63:0] ddr_read_data_i = '0;

   logic        recording_o, playing_o, trace_end_o;
   logic        memory_full_o, overflow_o, rd_valid_o;
   logic [63:0] rd_data_o, ddr_write_data_o;
   logic        ddr_write_o, ddr_read_o;
   logic [26:0] ddr_address_o;

   logic        s_recording_o, s_playing_o, s_trace_end_o;
   logic        s_memory_full_o, s_overflow_o, s_rd_valid_o;
   logic [63:0] s_rd_data_o, s_ddr_write_data_o;
   logic        s_ddr_write_o, s_ddr_read_o;
   logic [5:0]  s_ddr_address_o;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   audio_memory_scheduler dut (
      .clk_i(clk), .rst_i(rst_i),
      .start_record_i(start_record_i),
      .start_playback_i(start_playback_i),
      .stop_i(stop_i),
      .recording_o(recording_o), .playing_o(playing_o),
      .trace_end_o(trace_end_o), .memory_full_o(memory_full_o),
      .overflow_o(overflow_o),
      .wr_valid_i(wr_valid_i), .wr_data_i(wr_data_i),
      .rd_req_i(rd_req_i),
      .rd_valid_o(rd_valid_o), .rd_data_o(rd_data_o),
      .ddr_ready_i(ddr_ready_i),
      .ddr_write_o(ddr_write_o), .ddr_read_o(ddr_read_o),
      .ddr_address_o(ddr_address_o),
      .ddr_write_data_o(ddr_write_data_o),
      .ddr_write_done_i(ddr_write_done_i),
      .ddr_read_valid_i(ddr_read_valid_i),
      .ddr_read_data_i(ddr_read_data_i)
   );

   audio_memory_scheduler #(.ADDR_WIDTH(6)) dut_s (
      .clk_i(clk), .rst_i(rst_i),
      .start_record_i(start_record_i),
      .start_playback_i(start_playback_i),
      .stop_i(stop_i),
      .recording_o(s_recording_o), .playing_o(s_playing_o),
      .trace_end_o(s_trace_end_o), .memory_full_o(s_memory_full_o),
      .overflow_o(s_overflow_o),
      .wr_valid_i(wr_valid_i), .wr_data_i(wr_data_i),
      .rd_req_i(rd_req_i),
      .rd_valid_o(s_rd_valid_o), .rd_data_o(s_rd_data_o),
      .ddr_ready_i(ddr_ready_i),
      .ddr_write_o(s_ddr_write_o), .ddr_read_o(s_ddr_read_o),
      .ddr_address_o(s_ddr_address_o),
      .ddr_write_data_o(s_ddr_write_data_o),
      .ddr_write_done_i(ddr_write_done_i),
      .ddr_read_valid_i(ddr_read_valid_i),
      .ddr_read_data_i(ddr_read_data_i)
   );

   // DDR model and event log, sampled mid-cycle.
   logic [63:0] mem [logic [26:0]];
   logic [26:0] wa[$];
   logic [63:0] wd[$];
   logic [26:0] ra[$];
   logic [63:0] rv[$];
   logic [5:0]  s_wa[$];
   int          te_cnt = 0;
   int          cmd_cnt = 0;
   int          wcnt = 0;
   int          rcnt = 0;
   logic [63:0] rdat = '0;

   always @(negedge clk) begin
      ddr_write_done_i = 1'b0;
      ddr_read_valid_i = 1'b0;
      if (rst_i) begin
         wcnt = 0;
         rcnt = 0;
      end else begin
         if (wcnt > 0) begin
            wcnt--;
            if (wcnt == 0) ddr_write_done_i = 1'b1;
         end
         if (rcnt > 0) begin
            rcnt--;
            if (rcnt == 0) begin
               ddr_read_valid_i = 1'b1;
               ddr_read_data_i  = rdat;
            end
         end
         if (ddr_write_o) begin
            wa.push_back(ddr_address_o);
            wd.push_back(ddr_write_data_o);
            mem[ddr_address_o] = ddr_write_data_o;
            wcnt = 2;
         end
         if (ddr_read_o) begin
            ra.push_back(ddr_address_o);
            rdat = mem.exists(ddr_address_o) ? mem[ddr_address_o] : '0;
            rcnt = 3;
         end
         if (s_ddr_write_o) s_wa.push_back(s_ddr_address_o);
         if (rd_valid_o) rv.push_back(rd_data_o);
         if (trace_end_o) te_cnt++;
         if (ddr_write_o || ddr_read_o) cmd_cnt++;
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic clear_logs();
      wa.delete(); wd.delete(); ra.delete(); rv.delete(); s_wa.delete();
      te_cnt = 0;
      cmd_cnt = 0;
   endtask

   task automatic send_pkt(input logic [63:0] d);
      wr_valid_i = 1'b1;
      wr_data_i  = d;
      tick(1);
      wr_valid_i = 1'b0;
   endtask

   task automatic stop_and_drain();
      stop_i = 1'b1;
      tick(1);
      stop_i = 1'b0;
      for (int k = 0; k < 40 && recording_o; k++) tick(1);
   endtask

   task automatic test_reset();
      logic [7:0] flags;
      rst_i = 1'b1;
      tick(3);
      rst_i = 1'b0;
      flags = {recording_o, playing_o, trace_end_o, memory_full_o,
               overflow_o, rd_valid_o, ddr_write_o, ddr_read_o};
      n_tests++;
      if (flags !== 8'h00) begin
         n_fail++;
         $display("FAIL reset_flags: got %b want 00000000", flags);
      end
      n_tests++;
      if (ddr_address_o !== 27'h0) begin
         n_fail++;
         $display("FAIL reset_addr: got %h want 0", ddr_address_o);
      end
      n_tests++;
      if (rd_data_o !== 64'h0 || ddr_write_data_o !== 64'h0) begin
         n_fail++;
         $display("FAIL reset_data: got %h/%h want 0/0",
                  rd_data_o, ddr_write_data_o);
      end
      clear_logs();
      tick(10);
      n_tests++;
      if (cmd_cnt !== 0 || recording_o !== 1'b0 || playing_o !== 1'b0) begin
         n_fail++;
         $display("FAIL idle_quiet: got cmds=%0d rec=%b play=%b want 0/0/0",
                  cmd_cnt, recording_o, playing_o);
      end
   endtask

   task automatic test_record();
      logic [63:0] pk [3];
      pk[0] = 64'hAAAA_0000_1111_2222;
      pk[1] = 64'hBBBB_3333_4444_5555;
      pk[2] = 64'hCCCC_6666_7777_8888;
      clear_logs();
      start_record_i = 1'b1;
      tick(1);
      start_record_i = 1'b0;
      n_tests++;
      if (recording_o !== 1'b1) begin
         n_fail++;
         $display("FAIL rec_start: got %b want 1", recording_o);
      end
      for (int i = 0; i < 3; i++) begin
         send_pkt(pk[i]);
         tick(20);
      end
      stop_and_drain();
      n_tests++;
      if (recording_o !== 1'b0) begin
         n_fail++;
         $display("FAIL rec_drain: got rec=%b want 0", recording_o);
      end
      n_tests++;
      if (wa.size() !== 3) begin
         n_fail++;
         $display("FAIL rec_count: got %0d want 3", wa.size());
      end
      for (int i = 0; i < 3 && i < wa.size(); i++) begin
         n_tests++;
         if (wa[i] !== 27'(i * 8) || wd[i] !== pk[i]) begin
            n_fail++;
            $display("FAIL rec_write%0d: got %h/%h want %h/%h",
                     i, wa[i], wd[i], 27'(i * 8), pk[i]);
         end
      end
   endtask

   task automatic test_playback();
      logic [63:0] pk [3];
      pk[0] = 64'hAAAA_0000_1111_2222;
      pk[1] = 64'hBBBB_3333_4444_5555;
      pk[2] = 64'hCCCC_6666_7777_8888;
      clear_logs();
      start_playback_i = 1'b1;
      tick(1);
      start_playback_i = 1'b0;
      n_tests++;
      if (playing_o !== 1'b1) begin
         n_fail++;
         $display("FAIL play_start: got %b want 1", playing_o);
      end
      for (int k = 0; k < 3; k++) begin
         rd_req_i = 1'b1;
         tick(1);
         rd_req_i = 1'b0;
         for (int w = 0; w < 40 && rv.size() <= k; w++) tick(1);
      end
      tick(5);
      n_tests++;
      if (ra.size() !== 3 || rv.size() !== 3) begin
         n_fail++;
         $display("FAIL play_count: got rd=%0d val=%0d want 3/3",
                  ra.size(), rv.size());
      end
      for (int i = 0; i < 3 && i < ra.size() && i < rv.size(); i++) begin
         n_tests++;
         if (ra[i] !== 27'(i * 8) || rv[i] !== pk[i]) begin
            n_fail++;
            $display("FAIL play_read%0d: got %h/%h want %h/%h",
                     i, ra[i], rv[i], 27'(i * 8), pk[i]);
         end
      end
      n_tests++;
      if (te_cnt !== 1 || playing_o !== 1'b0) begin
         n_fail++;
         $display("FAIL play_end: got te=%0d play=%b want 1/0",
                  te_cnt, playing_o);
      end
   endtask

   task automatic test_overflow();
      clear_logs();
      ddr_ready_i = 1'b0;
      start_record_i = 1'b1;
      tick(1);
      start_record_i = 1'b0;
      send_pkt(64'hD1D1_D1D1_D1D1_D1D1);
      tick(2);
      send_pkt(64'hD2D2_D2D2_D2D2_D2D2);
      tick(2);
      n_tests++;
      if (overflow_o !== 1'b1 || wa.size() !== 0) begin
         n_fail++;
         $display("FAIL ovf_flag: got ovf=%b writes=%0d want 1/0",
                  overflow_o, wa.size());
      end
      ddr_ready_i = 1'b1;
      tick(10);
      n_tests++;
      if (wa.size() !== 1) begin
         n_fail++;
         $display("FAIL ovf_count: got %0d want 1", wa.size());
      end else begin
         n_tests++;
         if (wa[0] !== 27'h0 || wd[0] !== 64'hD1D1_D1D1_D1D1_D1D1) begin
            n_fail++;
            $display("FAIL ovf_write: got %h/%h want 0/d1d1d1d1d1d1d1d1",
                     wa[0], wd[0]);
         end
      end
      n_tests++;
      if (overflow_o !== 1'b1) begin
         n_fail++;
         $display("FAIL ovf_sticky: got %b want 1", overflow_o);
      end
      stop_and_drain();
   endtask

   task automatic test_simul_start();
      start_record_i = 1'b1;
      start_playback_i = 1'b1;
      tick(1);
      start_record_i = 1'b0;
      start_playback_i = 1'b0;
      n_tests++;
      if (recording_o !== 1'b1 || playing_o !== 1'b0) begin
         n_fail++;
         $display("FAIL both_start: got rec=%b play=%b want 1/0",
                  recording_o, playing_o);
      end
      stop_and_drain();
      n_tests++;
      if (recording_o !== 1'b0) begin
         n_fail++;
         $display("FAIL both_drain: got rec=%b want 0", recording_o);
      end
   endtask

   task automatic test_empty_trace();
      clear_logs();
      start_playback_i = 1'b1;
      tick(1);
      start_playback_i = 1'b0;
      n_tests++;
      if (playing_o !== 1'b1 || trace_end_o !== 1'b0) begin
         n_fail++;
         $display("FAIL empty_enter: got play=%b te=%b want 1/0",
                  playing_o, trace_end_o);
      end
      tick(1);
      n_tests++;
      if (trace_end_o !== 1'b1 || playing_o !== 1'b0) begin
         n_fail++;
         $display("FAIL empty_pulse: got te=%b play=%b want 1/0",
                  trace_end_o, playing_o);
      end
      tick(1);
      n_tests++;
      if (trace_end_o !== 1'b0) begin
         n_fail++;
         $display("FAIL empty_once: got te=%b want 0", trace_end_o);
      end
      tick(3);
      n_tests++;
      if (ra.size() !== 0) begin
         n_fail++;
         $display("FAIL empty_noread: got %0d reads want 0", ra.size());
      end
   endtask

   task automatic test_stop_in_play();
      start_record_i = 1'b1;
      tick(1);
      start_record_i = 1'b0;
      send_pkt(64'hEEEE_EEEE_0000_0001);
      tick(6);
      send_pkt(64'hFFFF_FFFF_0000_0002);
      tick(6);
      stop_and_drain();
      clear_logs();
      start_playback_i = 1'b1;
      tick(1);
      start_playback_i = 1'b0;
      rd_req_i = 1'b1;
      tick(1);
      rd_req_i = 1'b0;
      for (int w = 0; w < 20 && ra.size() == 0; w++) tick(1);
      n_tests++;
      if (ra.size() !== 1) begin
         n_fail++;
         $display("FAIL stop_issue: got %0d reads want 1", ra.size());
      end
      stop_i = 1'b1;
      tick(1);
      stop_i = 1'b0;
      tick(10);
      n_tests++;
      if (rv.size() !== 0 || te_cnt !== 0) begin
         n_fail++;
         $display("FAIL stop_discard: got val=%0d te=%0d want 0/0",
                  rv.size(), te_cnt);
      end
      n_tests++;
      if (playing_o !== 1'b0) begin
         n_fail++;
         $display("FAIL stop_play: got %b want 0", playing_o);
      end
      start_playback_i = 1'b1;
      tick(1);
      start_playback_i = 1'b0;
      n_tests++;
      if (playing_o !== 1'b1) begin
         n_fail++;
         $display("FAIL stop_idle: got play=%b want 1", playing_o);
      end
      stop_i = 1'b1;
      tick(1);
      stop_i = 1'b0;
      tick(10);
   endtask

   task automatic test_mem_full();
      clear_logs();
      start_record_i = 1'b1;
      tick(1);
      start_record_i = 1'b0;
      for (int i = 0; i < 9; i++) begin
         send_pkt(64'h5000 + 64'(i));
         tick(6);
      end
      n_tests++;
      if (s_memory_full_o !== 1'b1 || s_recording_o !== 1'b0) begin
         n_fail++;
         $display("FAIL full_flag: got full=%b rec=%b want 1/0",
                  s_memory_full_o, s_recording_o);
      end
      n_tests++;
      if (s_wa.size() !== 8) begin
         n_fail++;
         $display("FAIL full_count: got %0d want 8", s_wa.size());
      end
      for (int i = 0; i < 8 && i < s_wa.size(); i++) begin
         n_tests++;
         if (s_wa[i] !== 6'(i * 8)) begin
            n_fail++;
            $display("FAIL full_addr%0d: got %h want %h",
                     i, s_wa[i], 6'(i * 8));
         end
      end
      n_tests++;
      if (memory_full_o !== 1'b0 || wa.size() !== 9) begin
         n_fail++;
         $display("FAIL wide_nofull: got full=%b writes=%0d want 0/9",
                  memory_full_o, wa.size());
      end
      stop_and_drain();
   endtask

   initial begin
      test_reset();
      test_record();
      test_playback();
      test_overflow();
      test_simul_start();
      test_empty_trace();
      test_stop_in_play();
      test_mem_full();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/audio_memory_scheduler.md
Name: audio_memory_scheduler

Overview:
Sequences record/playback sessions and arbitrates the single DDR command port between the PCM packet writer (record path) and the playback packet reader.
- Owns write/read address generation, trace-length bookkeeping, end-of-trace detection, and a one-entry write holding buffer.
- Sits between the 64-bit sample packer, the playback controller and the DDR interface, replacing ad-hoc address counters at top level.

Parameters:
ADDR_WIDTH, 27, DDR byte-address width.
DATA_WIDTH, 64, packet width in bits.
PACKET_BYTES, 8, address increment per packet (DATA_WIDTH/8).

Ports:
clk_i  in  1  system clock.
rst_i  in  1  synchronous active-high reset.
start_record_i  in  1  request recording (sampled only in IDLE).
start_playback_i  in  1  request playback (sampled only in IDLE).
stop_i  in  1  abort current session.
recording_o  out  1  high in S_RECORD and S_DRAIN.
playing_o  out  1  high in S_PLAY.
trace_end_o  out  1  one-cycle pulse when playback consumed the whole trace.
memory_full_o  out  1  sticky; write pointer reached top of memory.
overflow_o  out  1  sticky; write packet dropped because holding buffer was full.
wr_valid_i  in  1  packet from packer.
wr_data_i  in  DATA_WIDTH  packet data.
rd_req_i  in  1  playback wants next packet (pulse).
rd_valid_o  out  1  read packet valid (one-cycle pulse).
rd_data_o  out  DATA_WIDTH  read packet.
ddr_ready_i  in  1  DDR accepts a command this cycle.
ddr_write_o  out  1  write command pulse.
ddr_read_o  out  1  read command pulse.
ddr_address_o  out  ADDR_WIDTH  command address, valid with command pulse.
ddr_write_data_o  out  DATA_WIDTH  write data, valid with ddr_write_o.
ddr_write_done_i  in  1  write completed.
ddr_read_valid_i  in  1  read data returned.
ddr_read_data_i  in  DATA_WIDTH  returned data.

Behaviour:
- Reset: all outputs 0, session FSM S_IDLE, memory FSM M_IDLE, wr_ptr/rd_ptr/trace_len 0, buffer empty, stickies cleared, rd_pending 0.
- Session FSM:
  - S_IDLE: start_record_i -> S_RECORD (wr_ptr<=0, memory_full_o<=0, overflow_o<=0). Else start_playback_i -> S_PLAY (rd_ptr<=0). Both high: record wins.
  - S_RECORD: stop_i or memory full -> S_DRAIN.
  - S_DRAIN: buffer empty and M_IDLE -> trace_len<=wr_ptr, S_IDLE.
  - S_PLAY:
    - rd_ptr==trace_len, M_IDLE, no pending -> trace_end_o pulse, S_IDLE.
    - stop_i -> S_STOP.
  - S_STOP: wait M_IDLE, -> S_IDLE; no trace_end_o.
  - Start inputs are ignored outside S_IDLE.
- Write buffer:
  - wr_valid_i in S_RECORD with buffer empty -> capture data, mark full.
  - wr_valid_i while buffer full -> drop packet, set overflow_o.
  - wr_valid_i outside S_RECORD is ignored.
  - A capture and a release of the buffer in the same cycle is allowed: the new packet is captured.
- Read request: rd_req_i in S_PLAY sets rd_pending; a second request while pending or outstanding is ignored. rd_req_i when rd_ptr==trace_len is ignored.
- Memory FSM (one outstanding command):
  - M_IDLE: if ddr_ready_i, pick a command. Priority: write (buffer full, wr_ptr below top) over read (rd_pending, rd_ptr<trace_len).
  - Write issue: ddr_write_o=1 for one cycle, ddr_address_o=wr_ptr, data from buffer; buffer freed; wr_ptr+=PACKET_BYTES; -> M_WRITE.
  - Read issue: ddr_read_o=1, ddr_address_o=rd_ptr, rd_pending<=0, rd_ptr+=PACKET_BYTES; -> M_READ.
  - M_WRITE: ddr_write_done_i -> M_IDLE.
  - M_READ: ddr_read_valid_i -> register data; rd_valid_o/rd_data_o the next cycle; -> M_IDLE.
  - In S_STOP the returned read data is discarded (rd_valid_o stays 0).
- Memory full: asserted when wr_ptr == 2^ADDR_WIDTH - PACKET_BYTES has been written (the pointer would wrap). Further writes are never issued; no wrap-around.
- Empty trace (trace_len 0) playback: trace_end_o pulses on the cycle after entering S_PLAY.
- Outputs are registered. ddr_address_o is 0 when no command is issued.
- rst_i mid-operation aborts immediately, including any outstanding command; a late ddr_*_done/valid arriving in M_IDLE is ignored.

Test Plan:
- Reset, then idle 10 cycles -> all outputs 0, no DDR commands.
- start_record_i; 3 wr_valid_i packets A,B,C spaced 20 cycles; done 2 cycles after each write; stop_i -> writes at 0x0,0x8,0x10 with data A,B,C. After S_DRAIN completes: trace_len=24, recording_o falls.
- Then start_playback_i; rd_req_i after each rd_valid_o -> reads at 0x0,0x8,0x10, rd_data_o = A,B,C. Exactly one trace_end_o pulse, then playing_o=0.
- Hold ddr_ready_i low; 2 wr_valid_i -> second packet dropped, overflow_o=1. After release, one write at 0x0 with the first packet.
- start_record_i and start_playback_i in the same cycle -> recording_o=1, playing_o=0.
- Playback with trace_len 0 -> trace_end_o pulses on the cycle after playing_o rises, and no ddr_read_o.
- ADDR_WIDTH=6, record 9 packets -> writes at 0x0..0x38, memory_full_o=1, 9th packet never written.
- stop_i in S_PLAY with a read outstanding -> rd_valid_o stays 0, no trace_end_o, S_IDLE after ddr_read_valid_i.
